// File: rtl/pe_dot_accum_if.sv
// Bus between the PE dot-product stage/control and the window accumulator.
// Control flags lead i_dot_result by DOT_LATENCY cycles; there is no backpressure.
interface pe_dot_accum_if #(
  parameter int NUM_DOTS         = 2,
  parameter int NUM_FEATURES     = 2,
  parameter int NUM_FILTERS      = 4,
  parameter int DOT_OUTPUT_WIDTH = 16,
  parameter int ACCUM_WIDTH      = 32
);
  logic i_valid;
  logic i_first;
  logic i_last;
  logic [NUM_DOTS-1:0][NUM_FEATURES-1:0][NUM_FILTERS-1:0][DOT_OUTPUT_WIDTH-1:0] i_dot_result;
  logic o_valid;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACCUM_WIDTH-1:0] o_result;
  logic o_overflow;
  logic o_protocol_err;

  modport master (
    output i_valid, i_first, i_last, i_dot_result,
    input  o_valid, o_result, o_overflow, o_protocol_err
  );

  modport slave (
    input  i_valid, i_first, i_last, i_dot_result,
    output o_valid, o_result, o_overflow, o_protocol_err
  );
endinterface

// File: rtl/pe_dot_accum.sv
// Sums dot lanes per (feature, filter) and accumulates over a first/last window; o_valid
// pulses DOT_LATENCY+1 cycles after the last beat's i_valid. No backpressure: every pulse must be taken.
module pe_dot_accum #(
  parameter int NUM_DOTS         = 2,
  parameter int NUM_FEATURES     = 2,
  parameter int NUM_FILTERS      = 4,
  parameter int DOT_OUTPUT_WIDTH = 16,
  parameter int ACCUM_WIDTH      = 32,
  parameter int DOT_LATENCY      = 4
) (
  input  logic         clock,
  input  logic         resetn,
  pe_dot_accum_if.slave bus
);
  localparam int SW = ACCUM_WIDTH + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state_q, state_d;
  logic [DOT_LATENCY-1:0][2:0] ctrl_q, ctrl_d;
  logic a_valid, a_first, a_last;
  logic open_win;

  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACCUM_WIDTH-1:0] result_q, result_d;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0][ACCUM_WIDTH-1:0] sat_n;
  logic [NUM_FEATURES-1:0][NUM_FILTERS-1:0]                  sat_hit;

  logic o_valid_q, o_valid_d;
  logic overflow_q, overflow_d;
  logic proto_err_q, proto_err_d;

  // Control flags ride a delay line so they meet their dot results.
  always_comb begin
    ctrl_d[0] = {bus.i_valid, bus.i_first, bus.i_last};
    for (int i = 1; i < DOT_LATENCY; i++) begin
      ctrl_d[i] = ctrl_q[i-1];
    end
  end

  assign {a_valid, a_first, a_last} = ctrl_q[DOT_LATENCY-1];
  assign open_win = (state_q == IDLE) || a_first;

  for (genvar gf = 0; gf < NUM_FEATURES; gf++) begin : g_feat
    for (genvar gk = 0; gk < NUM_FILTERS; gk++) begin : g_filt
      logic signed [SW-1:0] lane_sum;
      logic signed [SW-1:0] base;
      logic signed [SW-1:0] n;

      always_comb begin
        lane_sum = '0;
        for (int d = 0; d < NUM_DOTS; d++) begin
          lane_sum = lane_sum + SW'($signed(bus.i_dot_result[d][gf][gk]));
        end
      end

      assign base = open_win ? '0 : SW'($signed(acc_q[gf][gk]));
      assign n    = base + lane_sum;

      // Top two bits disagree exactly when n leaves the ACCUM_WIDTH signed range.
      assign sat_hit[gf][gk] = n[SW-1] ^ n[SW-2];
      assign sat_n[gf][gk]   = !sat_hit[gf][gk] ? n[ACCUM_WIDTH-1:0] :
                               (n[SW-1] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACCUM_WIDTH-1){1'b1}}});
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    o_valid_d   = 1'b0;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    if (a_valid) begin
      acc_d = sat_n;
      if (|sat_hit) begin
        overflow_d = 1'b1;
      end
      if (((state_q == IDLE) && !a_first) || ((state_q == ACCUM) && a_first)) begin
        proto_err_d = 1'b1;
      end
      if (a_last) begin
        o_valid_d = 1'b1;
        result_d  = sat_n;
        state_d   = IDLE;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      o_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      o_valid_q   <= o_valid_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.o_valid        = o_valid_q;
  assign bus.o_result       = result_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_protocol_err = proto_err_q;
endmodule
